// File: rtl/inst_queue.sv
// inst_queue: circular instruction buffer between fetch and decode, no bypass, flush clears occupancy.
module inst_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_inst,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_inst,
  output logic                       out_misalign,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic [DEPTH-1:0] mis_mem;
  logic push, pop;
  assign in_ready = count != (AW+1)'(DEPTH);
  assign out_valid = count != '0;
  assign push = in_valid && in_ready && !flush;
  assign pop = out_valid && out_ready && !flush;
  assign out_pc = pc_mem[rd_ptr];
  assign out_inst = inst_mem[rd_ptr];
  assign out_misalign = mis_mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  // storage is not reset; pointers alone define what is visible
  always_ff @(posedge clk) begin
    if (push && rst_n) begin
      pc_mem[wr_ptr] <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
      mis_mem[wr_ptr] <= in_pc[1:0] != 2'b00;
    end
  end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed and random stimulus checked each cycle against a queue-based model.
module tb_inst_queue;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_pc = 0, in_inst = 0;
  logic in_ready, out_valid, out_misalign;
  logic [31:0] out_pc, out_inst;
  logic [$clog2(DEPTH):0] count;
  int total = 0, bad = 0;
  bit chk_on = 0;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t q[$];
  int n;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
    .in_inst(in_inst), .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_inst(out_inst), .out_misalign(out_misalign), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    n = q.size();
    if (!rst_n) begin
      q.delete();
      chk_on = 1;
    end else if (flush) q.delete();
    else begin
      if (out_ready && n != 0) void'(q.pop_front());
      if (in_valid && n != DEPTH) q.push_back('{in_pc, in_inst});
    end
  end

  always @(negedge clk) if (chk_on) begin
    cmp("m_count", 32'(count), 32'(q.size()));
    cmp("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
    cmp("m_in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    if (q.size() != 0) begin
      cmp("m_out_pc", out_pc, q[0].pc);
      cmp("m_out_inst", out_inst, q[0].inst);
      cmp("m_misalign", 32'(out_misalign), 32'(q[0].pc[1:0] != 2'b00));
    end
  end

  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                     input logic ordy, input logic fl, input logic rn);
    in_valid = v; in_pc = pc; in_inst = ins; out_ready = ordy; flush = fl; rst_n = rn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cmp("rst_count", 32'(count), 0);
    cmp("rst_out_valid", 32'(out_valid), 0);
    cmp("rst_in_ready", 32'(in_ready), 1);
    cyc(1, 32'h8000_0000, 32'h0000_0013, 0, 0, 1);
    cmp("p1_valid", 32'(out_valid), 1);
    cmp("p1_pc", out_pc, 32'h8000_0000);
    cmp("p1_inst", out_inst, 32'h0000_0013);
    cmp("p1_count", 32'(count), 1);
    cmp("p1_mis", 32'(out_misalign), 0);
    for (int i = 1; i < 4; i++) cyc(1, 32'h8000_0000 + 4 * i, 32'h100 + i, 0, 0, 1);
    cmp("full_count", 32'(count), 4);
    cmp("full_in_ready", 32'(in_ready), 0);
    cyc(1, 32'h9000_0000, 32'hdead, 0, 0, 1);
    cmp("full_ignore", 32'(count), 4);
    for (int i = 0; i < 4; i++) begin
      cmp("drain_pc", out_pc, 32'h8000_0000 + 4 * i);
      cyc(0, 0, 0, 1, 0, 1);
    end
    cmp("drain_empty", 32'(out_valid), 0);
    for (int i = 0; i < 4; i++) cyc(1, 32'hA000_0000 + 4 * i, i, 0, 0, 1);
    cyc(1, 32'hB000_0000, 32'hbbbb, 1, 0, 1);
    cmp("fullpop_count", 32'(count), 3);
    cmp("fullpop_ready", 32'(in_ready), 1);
    for (int i = 1; i < 4; i++) begin
      cmp("fullpop_pc", out_pc, 32'hA000_0000 + 4 * i);
      cyc(0, 0, 0, 1, 0, 1);
    end
    cmp("fullpop_nowrite", 32'(out_valid), 0);
    cyc(1, 32'hC000_0000, 0, 0, 0, 1);
    cyc(1, 32'hC000_0004, 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      cmp("steady_pc", out_pc, 32'hC000_0000 + 4 * i);
      cyc(1, 32'hC000_0008 + 4 * i, i + 2, 1, 0, 1);
      cmp("steady_count", 32'(count), 2);
    end
    cyc(1, 32'hC000_0100, 0, 0, 0, 1);
    cmp("pre_flush", 32'(count), 3);
    cyc(1, 32'hE000_0000, 0, 1, 1, 1);
    cmp("flush_count", 32'(count), 0);
    cmp("flush_valid", 32'(out_valid), 0);
    cmp("flush_ready", 32'(in_ready), 1);
    cyc(1, 32'hD000_0000, 32'h55, 0, 0, 1);
    cmp("post_flush_pc", out_pc, 32'hD000_0000);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(1, 32'h8000_0002, 7, 0, 0, 1);
    cmp("mis_head", 32'(out_misalign), 1);
    cyc(1, 32'h8000_0004, 8, 0, 0, 1);
    cyc(1, 32'h8000_0008, 9, 0, 0, 1);
    cmp("pre_rst_count", 32'(count), 3);
    cyc(1, 32'h8000_000C, 10, 1, 1, 0);
    cmp("mid_rst_count", 32'(count), 0);
    cmp("mid_rst_valid", 32'(out_valid), 0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 2) == 0,
          $urandom_range(0, 31) == 0, $urandom_range(0, 99) != 0);
    cyc(0, 0, 0, 0, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; legal values 2, 4 and 8 only.
REQ-002 Port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 Port flush, input, 1 bit: discard all queued and incoming instructions (redirect or exception).
REQ-005 Port in_valid, input, 1 bit: the fetch stage presents a valid instruction (FetchInfo enable).
REQ-006 Port in_pc, input, 32 bits: PC of the presented instruction.
REQ-007 Port in_inst, input, 32 bits: instruction word.
REQ-008 Port in_ready, output, 1 bit: the queue can accept an instruction this cycle; the fetch stage stalls while low.
REQ-009 Port out_valid, output, 1 bit: the head entry is valid toward decode.
REQ-010 Port out_pc, output, 32 bits: PC of the head entry.
REQ-011 Port out_inst, output, 32 bits: instruction word of the head entry.
REQ-012 Port out_misalign, output, 1 bit: the head entry's PC has bits [1:0] != 0.
REQ-013 Port out_ready, input, 1 bit: decode consumes the head entry this cycle.
REQ-014 Port count, output, clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-015 The queue SHALL be a circular buffer of DEPTH entries, each holding {pc[31:0], inst[31:0], misalign}; rd_ptr and wr_ptr are clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-016 Push = in_valid && in_ready && !flush; the entry is written at wr_ptr and wr_ptr increments.
REQ-017 The misalign bit of a pushed entry SHALL equal (in_pc[1:0] != 2'b00).
REQ-018 Pop = out_valid && out_ready && !flush; rd_ptr increments.
REQ-019 in_ready SHALL equal (count != DEPTH) and depend only on registered state, never on out_ready or in_valid.
REQ-020 out_valid SHALL equal (count != 0); out_pc, out_inst and out_misalign SHALL be driven from the entry at rd_ptr.
REQ-021 There is no bypass: an instruction pushed in cycle N is visible at the output in cycle N+1 at the earliest.
REQ-022 On the next edge, count SHALL update as count + push - pop; a simultaneous push and pop leaves count unchanged and advances both pointers.
REQ-023 Full (count == DEPTH): in_ready = 0; in_valid is ignored; a pop in the same cycle lowers count to DEPTH-1, and in_ready rises in the following cycle.
REQ-024 Empty (count == 0): out_valid = 0; out_ready is ignored; out_pc, out_inst and out_misalign are don't-care.
REQ-025 flush = 1: on the next edge, count, rd_ptr and wr_ptr SHALL become 0; any push or pop in that cycle is suppressed; storage contents need not be cleared.
REQ-026 flush takes priority over push and pop in all cases, including full and empty.
REQ-027 in_pc, in_inst and entry storage SHALL NOT be gated by in_valid except through the write enable; outputs change only on a pop, a push into an empty queue, flush, or reset.

Reset
REQ-028 While rst_n = 0 at a rising edge: count = 0, rd_ptr = 0, wr_ptr = 0, and therefore out_valid = 0 and in_ready = 1 in the following cycle.
REQ-029 Reset SHALL override flush, push and pop; entry storage needs no reset.
REQ-030 Reset asserted mid-operation (any occupancy) SHALL leave the queue empty one cycle later, with no entry observable at the output afterwards.

Verification
REQ-031 Reset then push pc=0x80000000, inst=0x00000013 with out_ready=0 -> next cycle out_valid=1, out_pc=0x80000000, out_inst=0x00000013, count=1, out_misalign=0.
REQ-032 DEPTH=4: push pc 0x80000000, +4, +8, +C on consecutive cycles with out_ready=0 -> count=4 and in_ready=0; a fifth in_valid is ignored; then out_ready=1 for 4 cycles -> out_pc sequence 0x80000000..0x8000000C, then out_valid=0.
REQ-033 With count=4, assert in_valid and out_ready together -> next cycle count=3 and in_ready=1, and no new entry is written.
REQ-034 With count=2, assert push and pop together for 10 cycles -> count stays 2 and pointers wrap; output PCs follow input order with exactly 2 cycles of queue delay.
REQ-035 With count=3, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1; a push in the following cycle appears normally.
REQ-036 Push pc=0x80000002 -> that entry shows out_misalign=1 at the head; rst_n=0 asserted with count=3 -> next cycle count=0, out_valid=0.
